// File: rtl/wb_arb_2m_pkg.sv
// Shared Wishbone encodings: bus status, arbiter FSM states and arbiter defaults.
package wb_arb_2m_pkg;

  // Generic bus activity encodings used elsewhere in the codebase.
  localparam logic WB_IDLE = 1'b0;
  localparam logic WB_BUSY = 1'b1;

  // Two-master arbiter FSM state encodings.
  localparam logic [1:0] WB_ARB_IDLE = 2'd0;
  localparam logic [1:0] WB_ARB_GNT0 = 2'd1;
  localparam logic [1:0] WB_ARB_GNT1 = 2'd2;
  localparam logic [1:0] WB_ARB_ERR  = 2'd3;

  // Default number of cycles a granted strobe may wait for an ack.
  localparam int unsigned WB_ARB_TIMEOUT_DEF = 255;

endpackage

// File: rtl/wb_arb_2m.sv
// Two-master Wishbone arbiter (m0 = data side, m1 = instruction fetch) onto a
// single shared slave. Round-robin on ties, registered grant, per-grant ack
// timeout that terminates the stalled master with a one-cycle error.
module wb_arb_2m
  import wb_arb_2m_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = WB_ARB_TIMEOUT_DEF,
  parameter int unsigned AW          = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  // data-side master
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [AW-1:0] m0_dat_i,
  input  logic [3:0]    m0_sel_i,
  output logic [AW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  // instruction-fetch master
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [AW-1:0] m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  output logic [AW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  // shared slave
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_adr_o,
  output logic [AW-1:0] s_dat_o,
  output logic [3:0]    s_sel_o,
  input  logic [AW-1:0] s_dat_i,
  input  logic          s_ack_i,
  // current grant, one-hot
  output logic [1:0]    gnt_o
);

  localparam int unsigned   CW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYC);

  logic [1:0]    r_state;
  logic          r_last_gnt;   // 0 = m0 granted last, 1 = m1 granted last
  logic          r_err_m;      // master that timed out, valid in ERR
  logic          r_rst_done;   // holds off granting for one edge after reset
  logic [CW-1:0] r_cnt;

  logic [1:0]    w_state_nxt;
  logic          w_last_nxt;
  logic          w_err_m_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_cur_m;
  logic          w_cur_cyc;
  logic          w_cur_stb;

  assign w_gnt0    = (r_state == WB_ARB_GNT0);
  assign w_gnt1    = (r_state == WB_ARB_GNT1);
  assign gnt_o     = {w_gnt1, w_gnt0};
  assign w_cur_m   = w_gnt1;
  assign w_cur_cyc = w_cur_m ? m1_cyc_i : m0_cyc_i;
  assign w_cur_stb = w_cur_cyc & (w_cur_m ? m1_stb_i : m0_stb_i);
  assign w_cnt_inc = r_cnt + CW'(1);

  // Combinational bus mux: route the granted master to the slave and the
  // slave response back to that master only; everything else reads zero.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    if (w_gnt0) begin
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = w_cur_stb;
      s_we_o   = m0_we_i;
      s_adr_o  = m0_adr_i;
      s_dat_o  = m0_dat_i;
      s_sel_o  = m0_sel_i;
      m0_dat_o = s_dat_i;
      m0_ack_o = m0_cyc_i & s_ack_i;
    end else if (w_gnt1) begin
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = w_cur_stb;
      s_we_o   = m1_we_i;
      s_adr_o  = m1_adr_i;
      s_dat_o  = m1_dat_i;
      s_sel_o  = m1_sel_i;
      m1_dat_o = s_dat_i;
      m1_ack_o = m1_cyc_i & s_ack_i;
    end
    m0_err_o = (r_state == WB_ARB_ERR) & ~r_err_m;
    m1_err_o = (r_state == WB_ARB_ERR) &  r_err_m;
  end

  // Next-state logic: arbitration, release, and ack timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last_gnt;
    w_err_m_nxt = r_err_m;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      WB_ARB_IDLE: begin
        w_cnt_nxt = '0;
        if (r_rst_done) begin
          if (m0_cyc_i && m1_cyc_i) begin
            w_state_nxt = r_last_gnt ? WB_ARB_GNT0 : WB_ARB_GNT1;
          end else if (m0_cyc_i) begin
            w_state_nxt = WB_ARB_GNT0;
          end else if (m1_cyc_i) begin
            w_state_nxt = WB_ARB_GNT1;
          end
        end
      end
      WB_ARB_GNT0, WB_ARB_GNT1: begin
        // ack is tested before the timeout so an ack on the last allowed
        // cycle completes the transfer instead of raising an error
        if (!w_cur_cyc) begin
          w_state_nxt = WB_ARB_IDLE;
          w_last_nxt  = w_cur_m;
          w_cnt_nxt   = '0;
        end else if (s_ack_i) begin
          w_cnt_nxt = '0;
        end else if (w_cur_stb) begin
          if (w_cnt_inc == TO_VAL) begin
            w_state_nxt = WB_ARB_ERR;
            w_err_m_nxt = w_cur_m;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      WB_ARB_ERR: begin
        w_state_nxt = WB_ARB_IDLE;
        w_last_nxt  = r_err_m;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = WB_ARB_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= WB_ARB_IDLE;
      r_last_gnt <= 1'b1;
      r_err_m    <= 1'b0;
      r_rst_done <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_gnt <= w_last_nxt;
      r_err_m    <= w_err_m_nxt;
      r_rst_done <= 1'b1;
      r_cnt      <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_wb_arb_2m.sv
// Directed testbench for wb_arb_2m with hand-computed expectations.
module tb_wb_arb_2m;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic [3:0]  m0_sel_i;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m1_sel_i;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_ack_i;
  logic [1:0]  gnt_o;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  wb_arb_2m #(.TIMEOUT_CYC(4), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic m0_req(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = we;
    m0_adr_i = adr;  m0_dat_i = dat;  m0_sel_i = sel;
  endtask

  task automatic m1_req(input logic [31:0] adr);
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0;
    m1_adr_i = adr;  m1_dat_i = '0;   m1_sel_i = 4'hF;
  endtask

  task automatic m0_drop();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
  endtask

  task automatic m1_drop();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0;

    // reset state
    sample();
    check_eq("rst_gnt", 32'(gnt_o), 32'h0);
    check_eq("rst_stb", 32'(s_stb_o), 32'h0);
    check_eq("rst_cyc", 32'(s_cyc_o), 32'h0);
    check_eq("rst_ack", 32'({m1_ack_o, m0_ack_o, m1_err_o, m0_err_o}), 32'h0);
    step();

    // tie right after reset: m0 wins, one idle cycle, then m1
    step();
    rst_n = 1'b1;
    m0_req(1'b0, 32'h0000_0100, '0, 4'hF);
    m1_req(32'h0000_0200);
    sample(); check_eq("tie_p0_gnt", 32'(gnt_o), 32'h0);
    step(); sample(); check_eq("tie_first_edge_gnt", 32'(gnt_o), 32'h0);
    step();
    s_ack_i = 1'b1; s_dat_i = 32'h0000_0011;
    sample();
    check_eq("tie_gnt_m0", 32'(gnt_o), 32'h1);
    check_eq("tie_adr_m0", s_adr_o, 32'h0000_0100);
    check_eq("tie_m0_ack", 32'(m0_ack_o), 32'h1);
    check_eq("tie_m1_ack", 32'(m1_ack_o), 32'h0);
    check_eq("tie_m1_dat", m1_dat_o, 32'h0);
    step();
    s_ack_i = 1'b0; s_dat_i = '0; m0_drop();
    sample();
    check_eq("tie_rel_gnt", 32'(gnt_o), 32'h1);
    check_eq("tie_rel_stb", 32'(s_stb_o), 32'h0);
    check_eq("tie_rel_cyc", 32'(s_cyc_o), 32'h0);
    step(); sample();
    check_eq("tie_idle_gap", 32'(gnt_o), 32'h0);
    check_eq("tie_idle_stb", 32'(s_stb_o), 32'h0);
    step();
    s_ack_i = 1'b1;
    sample();
    check_eq("tie_gnt_m1", 32'(gnt_o), 32'h2);
    check_eq("tie_adr_m1", s_adr_o, 32'h0000_0200);
    check_eq("tie_m1_ack2", 32'(m1_ack_o), 32'h1);
    check_eq("tie_m0_ack2", 32'(m0_ack_o), 32'h0);
    step();
    s_ack_i = 1'b0; m1_drop();
    step(); sample(); check_eq("tie_end_gnt", 32'(gnt_o), 32'h0);

    // m0 read of 0x1000, ack after three wait cycles (same cycle the timeout would fire)
    step();
    m0_req(1'b0, 32'h0000_1000, '0, 4'hF);
    sample(); check_eq("rd_p0_gnt", 32'(gnt_o), 32'h0);
    step(); sample();
    check_eq("rd_gnt", 32'(gnt_o), 32'h1);
    check_eq("rd_adr", s_adr_o, 32'h0000_1000);
    check_eq("rd_stb", 32'(s_stb_o), 32'h1);
    check_eq("rd_we", 32'(s_we_o), 32'h0);
    check_eq("rd_noack", 32'(m0_ack_o), 32'h0);
    step(); step();
    step();
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    sample();
    check_eq("rd_ack", 32'(m0_ack_o), 32'h1);
    check_eq("rd_dat", m0_dat_o, 32'hDEAD_BEEF);
    check_eq("rd_m1_ack", 32'(m1_ack_o), 32'h0);
    check_eq("rd_ack_at_to_err", 32'(m0_err_o), 32'h0);
    check_eq("rd_ack_gnt", 32'(gnt_o), 32'h1);
    step();
    s_ack_i = 1'b0; s_dat_i = '0; m0_drop();
    sample(); check_eq("rd_no_err", 32'(m0_err_o), 32'h0);
    step(); sample(); check_eq("rd_end_gnt", 32'(gnt_o), 32'h0);

    // m0 write, sel 0011
    step();
    m0_req(1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011);
    step(); sample();
    check_eq("wr_gnt", 32'(gnt_o), 32'h1);
    check_eq("wr_we", 32'(s_we_o), 32'h1);
    check_eq("wr_sel", 32'(s_sel_o), 32'h3);
    check_eq("wr_dat", s_dat_o, 32'h1234_5678);
    check_eq("wr_noack", 32'(m0_ack_o), 32'h0);
    step();
    s_ack_i = 1'b1;
    sample(); check_eq("wr_ack", 32'(m0_ack_o), 32'h1);
    step();
    s_ack_i = 1'b0; m0_drop();
    sample(); check_eq("wr_single_ack", 32'(m0_ack_o), 32'h0);
    step(); sample(); check_eq("wr_end_gnt", 32'(gnt_o), 32'h0);

    // m1 flush: cyc drops before ack, late ack ignored
    step();
    m1_req(32'h0000_3000);
    step(); sample();
    check_eq("fl_gnt", 32'(gnt_o), 32'h2);
    check_eq("fl_stb", 32'(s_stb_o), 32'h1);
    step();
    m1_cyc_i = 1'b0;
    sample();
    check_eq("fl_drop_stb", 32'(s_stb_o), 32'h0);
    check_eq("fl_drop_cyc", 32'(s_cyc_o), 32'h0);
    step();
    m1_stb_i = 1'b0; s_ack_i = 1'b1; s_dat_i = 32'h5555_AAAA;
    sample();
    check_eq("fl_late_ack", 32'(m1_ack_o), 32'h0);
    check_eq("fl_late_dat", m1_dat_o, 32'h0);
    check_eq("fl_idle_gnt", 32'(gnt_o), 32'h0);
    step();
    s_ack_i = 1'b0; s_dat_i = '0;

    // timeout with TIMEOUT_CYC = 4: slave never acks
    m0_req(1'b0, 32'h0000_4000, '0, 4'hF);
    for (int unsigned i = 0; i < 4; i++) begin
      step(); sample();
      check_eq($sformatf("to_wait%0d_err", i), 32'(m0_err_o), 32'h0);
      check_eq($sformatf("to_wait%0d_gnt", i), 32'(gnt_o), 32'h1);
    end
    step();
    m0_drop();
    sample();
    check_eq("to_err", 32'(m0_err_o), 32'h1);
    check_eq("to_m1_err", 32'(m1_err_o), 32'h0);
    check_eq("to_err_gnt", 32'(gnt_o), 32'h0);
    check_eq("to_err_stb", 32'(s_stb_o), 32'h0);
    step(); sample();
    check_eq("to_err_once", 32'(m0_err_o), 32'h0);
    check_eq("to_end_gnt", 32'(gnt_o), 32'h0);

    // asynchronous reset while m1 holds a pending strobe
    step();
    m1_req(32'h0000_5000);
    step(); sample();
    check_eq("ar_gnt", 32'(gnt_o), 32'h2);
    check_eq("ar_stb", 32'(s_stb_o), 32'h1);
    step();
    #2;
    rst_n = 1'b0; s_ack_i = 1'b1; s_dat_i = 32'hCAFE_F00D;
    #1;
    check_eq("ar_async_gnt", 32'(gnt_o), 32'h0);
    check_eq("ar_async_stb", 32'(s_stb_o), 32'h0);
    check_eq("ar_async_cyc", 32'(s_cyc_o), 32'h0);
    check_eq("ar_async_ack", 32'(m1_ack_o), 32'h0);
    check_eq("ar_async_dat", m1_dat_o, 32'h0);
    m1_drop(); s_ack_i = 1'b0;
    step(); step();
    rst_n = 1'b1; s_ack_i = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      sample();
      check_eq($sformatf("ar_post%0d_resp", i), 32'({m1_ack_o, m1_err_o, m0_ack_o, m0_err_o}), 32'h0);
      check_eq($sformatf("ar_post%0d_gnt", i), 32'(gnt_o), 32'h0);
      step();
    end
    s_ack_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
